// File: rtl/grid_pkg.sv
// Shared constants and types for the step-sequencer grid redraw scheduler.
// Holds default geometry, the scheduler FSM encoding and cell colour states.
package grid_pkg;

    localparam int DEF_COLS  = 16;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_X0    = 40;
    localparam int DEF_Y0    = 100;
    localparam int DEF_PITCH = 36;
    localparam int DEF_CELL  = 30;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        IDLE,
        ISSUE,
        WAIT_DONE
    } fsm_t;

    localparam logic CELL_ON  = 1'b1;
    localparam logic CELL_OFF = 1'b0;

endpackage

// File: rtl/grid_redraw_scheduler_rr_pick.sv
// Round-robin first-set finder: lowest set bit at or after ptr, wrapping.
// Purely combinational; found=0 when the pending vector is empty.
module rr_pick #(
    parameter int N  = 64,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int k;

    // Scan offsets from far to near so the nearest hit is assigned last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (pend[IW'(k)]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/grid_redraw_scheduler.sv
// Grid cell state/pending tracker issuing redraws to one square drawer.
// Optional GRID_CLEAR_ALL_EN adds clear_all: blank grid, redraw every cell.
module grid_redraw_scheduler
    import grid_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int X0    = DEF_X0,
    parameter int Y0    = DEF_Y0,
    parameter int PITCH = DEF_PITCH,
    parameter int CELL  = DEF_CELL
) (
    input  logic                      CLOCK_50,
    input  logic                      nReset,
    input  logic                      toggle_valid,
    input  logic [$clog2(COLS)-1:0]   toggle_col,
    input  logic [$clog2(ROWS)-1:0]   toggle_row,
`ifdef GRID_CLEAR_ALL_EN
    input  logic                      clear_all,
`endif
    input  logic                      bg_ready,
    input  logic                      draw_done,
    output logic                      draw_start,
    output logic [9:0]                draw_x,
    output logic [8:0]                draw_y,
    output logic                      draw_state,
    output logic [COLS*ROWS-1:0]      cell_states,
    output logic                      busy
);

    localparam int N    = COLS * ROWS;
    localparam int IW   = $clog2(N);
    localparam int XMAX = X0 + (COLS - 1) * PITCH;
    localparam int YMAX = Y0 + (ROWS - 1) * PITCH + CELL - 1;

    if (XMAX > 1023 || YMAX > 511) begin : g_coord_overflow
        $error("grid geometry exceeds draw_x/draw_y range");
    end

    fsm_t          fsm;
    logic [N-1:0]  pending;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cur_idx;

    logic [N-1:0]  state_n;
    logic [N-1:0]  pend_n;
    logic [N-1:0]  pend_set;
    logic [N-1:0]  pend_clr;
    logic [N-1:0]  pend_rearm;
    logic [IW-1:0] t_idx;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] ptr_n;
    logic          found;
    logic [9:0]    x_calc;
    logic [8:0]    y_calc;
    int            col_i;
    int            row_i;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .pend  (pending),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // Next bitmaps: toggles/clear set pending, issue clears it, a drop re-arms.
    always_comb begin
        state_n    = cell_states;
        pend_set   = '0;
        pend_clr   = '0;
        pend_rearm = '0;
        t_idx      = IW'(int'(toggle_row) * COLS + int'(toggle_col));
`ifdef GRID_CLEAR_ALL_EN
        if (clear_all) begin
            state_n  = {N{CELL_OFF}};
            pend_set = '1;
        end else if (toggle_valid) begin
            state_n[t_idx]  = ~cell_states[t_idx];
            pend_set[t_idx] = 1'b1;
        end
`else
        if (toggle_valid) begin
            state_n[t_idx]  = ~cell_states[t_idx];
            pend_set[t_idx] = 1'b1;
        end
`endif
        if (fsm == ISSUE) pend_clr[cur_idx] = 1'b1;
        if ((fsm == ISSUE || fsm == WAIT_DONE) && !bg_ready)
            pend_rearm[cur_idx] = 1'b1;
        pend_n = (pending & ~pend_clr) | pend_set | pend_rearm;
        ptr_n  = (cur_idx == IW'(N - 1)) ? '0 : cur_idx + 1'b1;
    end

    // Pixel position of the cell the picker has selected.
    always_comb begin
        col_i  = int'(pick_idx) % COLS;
        row_i  = int'(pick_idx) / COLS;
        x_calc = 10'(X0 + col_i * PITCH);
        y_calc = 9'(Y0 + row_i * PITCH + CELL - 1);
    end

    // Scheduler FSM with registered handshake outputs and bitmaps.
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            fsm         <= WAIT_SYNC;
            pending     <= '0;
            cell_states <= '0;
            ptr         <= '0;
            cur_idx     <= '0;
            draw_start  <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_state  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cell_states <= state_n;
            pending     <= pend_n;
            draw_start  <= 1'b0;
            busy        <= (|pending) || fsm == ISSUE || fsm == WAIT_DONE;
            if (fsm == ISSUE) ptr <= ptr_n;
            if (!bg_ready) begin
                fsm <= WAIT_SYNC;
            end else begin
                unique case (fsm)
                    WAIT_SYNC: fsm <= IDLE;
                    IDLE: begin
                        if (found) begin
                            cur_idx    <= pick_idx;
                            draw_x     <= x_calc;
                            draw_y     <= y_calc;
                            draw_state <= state_n[pick_idx];
                            draw_start <= 1'b1;
                            fsm        <= ISSUE;
                        end
                    end
                    ISSUE:     fsm <= WAIT_DONE;
                    WAIT_DONE: if (draw_done) fsm <= IDLE;
                    default:   fsm <= WAIT_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grid_redraw_scheduler.sv
// Directed bench for grid_redraw_scheduler: table of single-cell redraws
// plus hand sequences for ordering, collapse, in-flight and sync-loss cases.
module tb_grid_redraw_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        nReset = 1'b0;
    logic        toggle_valid = 1'b0;
    logic [3:0]  toggle_col = '0;
    logic [1:0]  toggle_row = '0;
    logic        bg_ready = 1'b0;
    logic        draw_done = 1'b0;
`ifdef GRID_CLEAR_ALL_EN
    logic        clear_all = 1'b0;
`endif
    logic        draw_start;
    logic [9:0]  draw_x;
    logic [8:0]  draw_y;
    logic        draw_state;
    logic [63:0] cell_states;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model = '0;

    typedef struct {
        int   x;
        int   y;
        logic st;
    } draw_t;

    typedef struct {
        logic [3:0] col;
        logic [1:0] row;
        int         x;
        int         y;
        logic       st;
    } vec_t;

    draw_t obs_q[$];
    vec_t  vecs[5];

    grid_redraw_scheduler dut (
        .CLOCK_50     (CLOCK_50),
        .nReset       (nReset),
        .toggle_valid (toggle_valid),
        .toggle_col   (toggle_col),
        .toggle_row   (toggle_row),
`ifdef GRID_CLEAR_ALL_EN
        .clear_all    (clear_all),
`endif
        .bg_ready     (bg_ready),
        .draw_done    (draw_done),
        .draw_start   (draw_start),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_state   (draw_state),
        .cell_states  (cell_states),
        .busy         (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50)
        if (draw_start)
            obs_q.push_back('{int'(draw_x), int'(draw_y), draw_state});

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic toggle(input int c, input int r);
        toggle_valid = 1'b1;
        toggle_col   = 4'(c);
        toggle_row   = 2'(r);
        model[r * 16 + c] = ~model[r * 16 + c];
        @(negedge CLOCK_50);
        toggle_valid = 1'b0;
    endtask

    task automatic get_draw(output draw_t d, output bit got);
        got = 1'b0;
        d   = '{0, 0, 1'b0};
        for (int i = 0; i < 60; i++) begin
            if (obs_q.size() > 0) begin
                d   = obs_q.pop_front();
                got = 1'b1;
                return;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic hold_done(input draw_t d, input int hold, input string nm);
        bit stable;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLOCK_50);
            if (draw_x !== 10'(d.x) || draw_y !== 9'(d.y)) stable = 1'b0;
            if (draw_state !== d.st) stable = 1'b0;
            if (obs_q.size() != 0) stable = 1'b0;
        end
        chk({nm, " hold"}, 64'(stable), 64'd1);
        draw_done = 1'b1;
        @(negedge CLOCK_50);
        draw_done = 1'b0;
    endtask

    task automatic serve(input int ex, input int ey, input logic est,
                         input string nm, input int hold);
        draw_t d;
        bit    got;
        get_draw(d, got);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s draw_start absent after 60 cycles, required 1", nm);
            return;
        end
        chk({nm, " x"}, 64'(d.x), 64'(ex));
        chk({nm, " y"}, 64'(d.y), 64'(ey));
        chk({nm, " st"}, 64'(d.st), 64'(est));
        hold_done(d, hold, nm);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk({nm, " busy"}, 64'(busy), 64'd0);
        chk({nm, " cells"}, cell_states, model);
    endtask

    initial begin
        draw_t d;
        bit    got;
        bit    all_off;
        int    cnt;

        vecs[0] = '{4'd1,  2'd0, 76,  129, 1'b1};
        vecs[1] = '{4'd15, 2'd0, 580, 129, 1'b1};
        vecs[2] = '{4'd0,  2'd3, 40,  237, 1'b1};
        vecs[3] = '{4'd8,  2'd2, 328, 201, 1'b1};
        vecs[4] = '{4'd1,  2'd0, 76,  129, 1'b0};

        repeat (2) @(negedge CLOCK_50);
        chk("rst start", 64'(draw_start), 64'd0);
        chk("rst x", 64'(draw_x), 64'd0);
        chk("rst y", 64'(draw_y), 64'd0);
        chk("rst state", 64'(draw_state), 64'd0);
        chk("rst cells", cell_states, 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        nReset = 1'b1;
        @(negedge CLOCK_50);

        toggle(3, 1);
        repeat (10) @(negedge CLOCK_50);
        chk("nosync starts", 64'(obs_q.size()), 64'd0);
        chk("nosync busy", 64'(busy), 64'd1);
        chk("nosync cell19", 64'(cell_states[19]), 64'd1);
        bg_ready = 1'b1;
        serve(148, 165, 1'b1, "first", 2);
        wait_idle("first");

        for (int i = 0; i < 5; i++) begin
            toggle(int'(vecs[i].col), int'(vecs[i].row));
            serve(vecs[i].x, vecs[i].y, vecs[i].st, $sformatf("vec%0d", i), 3);
            wait_idle($sformatf("vec%0d", i));
        end

        toggle(0, 0);
        toggle(15, 3);
        toggle(5, 0);
        serve(40, 129, 1'b1, "ord0", 4);
        serve(220, 129, 1'b1, "ord1", 4);
        serve(580, 237, 1'b1, "ord2", 4);
        wait_idle("order");

        toggle(2, 2);
        toggle(2, 2);
        serve(112, 201, 1'b0, "dbl", 2);
        repeat (6) @(negedge CLOCK_50);
        chk("dbl extra", 64'(obs_q.size()), 64'd0);
        wait_idle("dbl");

        toggle(4, 3);
        get_draw(d, got);
        chk("inflt got", 64'(got), 64'd1);
        chk("inflt x", 64'(d.x), 64'd184);
        chk("inflt y", 64'(d.y), 64'd237);
        chk("inflt st", 64'(d.st), 64'd1);
        toggle(4, 3);
        hold_done(d, 3, "inflt");
        serve(184, 237, 1'b0, "inflt redo", 2);
        wait_idle("inflt");

        toggle(7, 1);
        get_draw(d, got);
        chk("drop got", 64'(got), 64'd1);
        chk("drop x", 64'(d.x), 64'd292);
        chk("drop y", 64'(d.y), 64'd165);
        @(negedge CLOCK_50);
        bg_ready = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk("drop starts", 64'(obs_q.size()), 64'd0);
        chk("drop busy", 64'(busy), 64'd1);
        bg_ready = 1'b1;
        serve(292, 165, 1'b1, "drop redo", 2);
        wait_idle("drop");

        draw_done = 1'b1;
        @(negedge CLOCK_50);
        draw_done = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk("stray done", 64'(obs_q.size()), 64'd0);
        chk("stray busy", 64'(busy), 64'd0);

`ifdef GRID_CLEAR_ALL_EN
        toggle(9, 0);
        serve(364, 129, 1'b1, "pre0", 1);
        toggle(10, 1);
        serve(400, 165, 1'b1, "pre1", 1);
        toggle(11, 2);
        serve(436, 201, 1'b1, "pre2", 1);
        toggle(12, 3);
        serve(472, 237, 1'b1, "pre3", 1);
        wait_idle("pre");
        clear_all = 1'b1;
        @(negedge CLOCK_50);
        clear_all = 1'b0;
        model   = '0;
        all_off = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 64; i++) begin
            get_draw(d, got);
            if (!got) break;
            cnt++;
            if (d.st !== 1'b0) all_off = 1'b0;
            @(negedge CLOCK_50);
            draw_done = 1'b1;
            @(negedge CLOCK_50);
            draw_done = 1'b0;
        end
        chk("clr count", 64'(cnt), 64'd64);
        chk("clr all off", 64'(all_off), 64'd1);
        repeat (6) @(negedge CLOCK_50);
        chk("clr extra", 64'(obs_q.size()), 64'd0);
        wait_idle("clr");
`else
        all_off = 1'b0;
        cnt     = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
